// File: rtl/uart_peripheral.sv
// Memory-mapped UART slave: TXD/RXD/CON registers, 8N1 serialiser/deserialiser and level IRQ.
// Define UART_LOOPBACK_EN to add CON.lb, which routes the TX line into the RX path internally.
module uart_peripheral #(
  parameter int unsigned BAUD_DIV  = 5208,
  parameter logic [31:0] BASE_ADDR = 32'h40000018
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        rd_i,
  input  logic        wr_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic        irqout_o
);

  localparam logic [31:0] TXD_ADDR = BASE_ADDR;
  localparam logic [31:0] RXD_ADDR = BASE_ADDR + 32'd4;
  localparam logic [31:0] CON_ADDR = BASE_ADDR + 32'd8;
  localparam logic [15:0] BIT_END  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_END = 16'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic wr_txd, wr_con, rd_rxd, rd_con;
  assign wr_txd = wr_i & (addr_i == TXD_ADDR);
  assign wr_con = wr_i & (addr_i == CON_ADDR);
  assign rd_rxd = rd_i & (addr_i == RXD_ADDR);
  assign rd_con = rd_i & (addr_i == CON_ADDR);

  logic tx_irq_en_q, rx_irq_en_q, lb;
  logic unused_wdata;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tx_irq_en_q <= 1'b0;
      rx_irq_en_q <= 1'b0;
    end else if (wr_con) begin
      tx_irq_en_q <= wdata_i[0];
      rx_irq_en_q <= wdata_i[1];
    end
  end

`ifdef UART_LOOPBACK_EN
  logic lb_q;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)     lb_q <= 1'b0;
    else if (wr_con) lb_q <= wdata_i[7];
  end
  assign lb = lb_q;
  assign unused_wdata = ^{wdata_i[31:8], wdata_i[6:2]};
`else
  assign lb = 1'b0;
  assign unused_wdata = ^{wdata_i[31:8], wdata_i[7:2]};
`endif

  state_e      tx_state_q;
  logic [15:0] tx_cnt_q;
  logic [2:0]  tx_bit_q;
  logic [7:0]  tx_byte_q;
  logic        tx_line_q, tx_done_q, tx_busy;

  assign tx_busy = (tx_state_q != S_IDLE);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
      tx_line_q  <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      if (rd_con) tx_done_q <= 1'b0;
      case (tx_state_q)
        S_IDLE: if (wr_txd) begin
          tx_byte_q  <= wdata_i[7:0];
          tx_line_q  <= 1'b0;
          tx_cnt_q   <= '0;
          tx_state_q <= S_START;
        end
        S_START: if (tx_cnt_q == BIT_END) begin
          tx_cnt_q   <= '0;
          tx_bit_q   <= '0;
          tx_line_q  <= tx_byte_q[0];
          tx_state_q <= S_DATA;
        end else tx_cnt_q <= tx_cnt_q + 16'd1;
        S_DATA: if (tx_cnt_q == BIT_END) begin
          tx_cnt_q <= '0;
          if (tx_bit_q == 3'd7) begin
            tx_line_q  <= 1'b1;
            tx_state_q <= S_STOP;
          end else begin
            tx_bit_q  <= tx_bit_q + 3'd1;
            tx_line_q <= tx_byte_q[tx_bit_q + 3'd1];
          end
        end else tx_cnt_q <= tx_cnt_q + 16'd1;
        S_STOP: if (tx_cnt_q == BIT_END) begin
          tx_cnt_q   <= '0;
          tx_done_q  <= 1'b1;
          tx_state_q <= S_IDLE;
        end else tx_cnt_q <= tx_cnt_q + 16'd1;
        default: tx_state_q <= S_IDLE;
      endcase
    end
  end

  assign uart_tx_o = lb ? 1'b1 : tx_line_q;

  logic [1:0] rx_sync_q;
  logic       rx_s;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) rx_sync_q <= 2'b11;
    else         rx_sync_q <= {rx_sync_q[0], (lb ? tx_line_q : uart_rx_i)};
  end
  assign rx_s = rx_sync_q[1];

  state_e      rx_state_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_shift_q, rx_byte_q;
  logic        rx_ready_q, overrun_q, frame_err_q;

  // Clears are written first so a same-cycle set from the FSM overrides them.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rx_state_q  <= S_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_byte_q   <= '0;
      rx_ready_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (rd_rxd) rx_ready_q <= 1'b0;
      if (rd_con) begin
        overrun_q   <= 1'b0;
        frame_err_q <= 1'b0;
      end
      case (rx_state_q)
        S_IDLE: if (!rx_s) begin
          rx_cnt_q   <= '0;
          rx_state_q <= S_START;
        end
        S_START: if (rx_cnt_q == HALF_END) begin
          rx_cnt_q   <= '0;
          rx_bit_q   <= '0;
          rx_state_q <= rx_s ? S_IDLE : S_DATA;
        end else rx_cnt_q <= rx_cnt_q + 16'd1;
        S_DATA: if (rx_cnt_q == BIT_END) begin
          rx_cnt_q   <= '0;
          rx_shift_q <= {rx_s, rx_shift_q[7:1]};
          rx_bit_q   <= rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_q <= S_STOP;
        end else rx_cnt_q <= rx_cnt_q + 16'd1;
        S_STOP: if (rx_cnt_q == BIT_END) begin
          rx_cnt_q   <= '0;
          rx_state_q <= S_IDLE;
          if (rx_s) begin
            rx_byte_q  <= rx_shift_q;
            rx_ready_q <= 1'b1;
            if (rx_ready_q) overrun_q <= 1'b1;
          end else begin
            frame_err_q <= 1'b1;
          end
        end else rx_cnt_q <= rx_cnt_q + 16'd1;
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  logic irq_q;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) irq_q <= 1'b0;
    else         irq_q <= (tx_irq_en_q & tx_done_q) | (rx_irq_en_q & rx_ready_q);
  end
  assign irqout_o = irq_q;

  logic [7:0] con_word;
  assign con_word = {lb, overrun_q, frame_err_q, tx_busy, rx_ready_q, tx_done_q,
                     rx_irq_en_q, tx_irq_en_q};

  always_comb begin
    rdata_o = '0;
    if (rd_i) begin
      if (addr_i == TXD_ADDR)      rdata_o = {24'b0, tx_byte_q};
      else if (addr_i == RXD_ADDR) rdata_o = {24'b0, rx_byte_q};
      else if (addr_i == CON_ADDR) rdata_o = {24'b0, con_word};
    end
  end

endmodule
